// File: rtl/msrv32_muldiv_unit.sv
// msrv32 iterative RV32M multiply/divide unit (shift-add / restoring).
// Optional MSRV32_FAST_MUL_EN: single-cycle 33x33 signed multiplier.
module msrv32_muldiv_unit (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        start_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] rs_1_in,
  input  logic [31:0] rs_2_in,
  input  logic [4:0]  rd_addr_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        wr_en_out,
  output logic [4:0]  rd_addr_out,
  output logic [31:0] rd_out
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rda_q, rda_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rd_q, rd_d;
  logic [63:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic        busy_q, busy_d;

  logic        is_div, s1, s2;
  logic        a_neg, b_neg;
  logic        dz, ovf;
  logic [31:0] a_mag, b_mag;
  logic [32:0] msum, dsub;
  logic [63:0] prod_c;
  logic [31:0] word, res;

  assign is_div = funct3_in[2];
  assign s1 = is_div ? ~funct3_in[0]
                     : (funct3_in[1] ^ funct3_in[0]);
  assign s2 = is_div ? ~funct3_in[0]
                     : (funct3_in[1:0] == 2'b01);
  assign a_neg = s1 & rs_1_in[31];
  assign b_neg = s2 & rs_2_in[31];
  assign a_mag = a_neg ? (32'd0 - rs_1_in) : rs_1_in;
  assign b_mag = b_neg ? (32'd0 - rs_2_in) : rs_2_in;
  assign dz  = (rs_2_in == 32'd0);
  assign ovf = ~funct3_in[0]
             & (rs_1_in == 32'h8000_0000)
             & (rs_2_in == 32'hFFFF_FFFF);

`ifdef MSRV32_FAST_MUL_EN
  logic        a_top, b_top;
  logic [63:0] fa, fb, fprod;
  assign a_top = s1 & rs_1_in[31];
  assign b_top = s2 & rs_2_in[31];
  assign fa = {{32{a_top}}, rs_1_in};
  assign fb = {{32{b_top}}, rs_2_in};
  assign fprod = fa * fb;
`endif

  // Multiply adds into the high half then shifts right;
  // divide shifts the {rem,quo} pair left and trial-subtracts.
  assign msum = {1'b0, acc_q[63:32]}
              + {1'b0, (b_q[0] ? a_q : 32'd0)};
  assign dsub = acc_q[63:31] - {1'b0, b_q};

  assign prod_c = neg_q ? (64'd0 - acc_q) : acc_q;
  assign word = f3_q[1] ? acc_q[63:32] : acc_q[31:0];

  always_comb begin
    res = neg_q ? (32'd0 - word) : word;
    if (!f3_q[2]) begin
      res = (f3_q == 3'b000) ? prod_c[31:0]
                             : prod_c[63:32];
    end
  end

  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    rda_d   = rda_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          f3_d    = funct3_in;
          rda_d   = rd_addr_in;
          a_d     = a_mag;
          b_d     = b_mag;
          neg_d   = (is_div && funct3_in[1]) ? a_neg
                                             : (a_neg ^ b_neg);
          acc_d   = is_div ? {32'd0, a_mag} : 64'd0;
          cnt_d   = 6'd0;
          busy_d  = 1'b1;
          state_d = CALC;
          if (is_div && dz) begin
            acc_d   = {rs_1_in, 32'hFFFF_FFFF};
            neg_d   = 1'b0;
            state_d = DONE;
          end else if (is_div && ovf) begin
            acc_d   = {32'd0, 32'h8000_0000};
            neg_d   = 1'b0;
            state_d = DONE;
          end
`ifdef MSRV32_FAST_MUL_EN
          else if (!is_div) begin
            acc_d   = fprod;
            neg_d   = 1'b0;
            state_d = DONE;
          end
`endif
        end
      end
      CALC: begin
        cnt_d = cnt_q + 6'd1;
        if (f3_q[2]) begin
          if (!dsub[32]) begin
            acc_d = {dsub[31:0], acc_q[30:0], 1'b1};
          end else begin
            acc_d = {acc_q[62:0], 1'b0};
          end
        end else begin
          acc_d = {msum, acc_q[31:1]};
          b_d   = {1'b0, b_q[31:1]};
        end
        if (cnt_q == 6'd31) begin
          state_d = DONE;
        end
      end
      DONE: begin
        rd_d    = res;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q <= IDLE;
      f3_q    <= 3'd0;
      rda_q   <= 5'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      rd_q    <= 32'd0;
      acc_q   <= 64'd0;
      cnt_q   <= 6'd0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      rda_q   <= rda_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_out    = busy_q;
  assign done_out    = (state_q == DONE);
  assign wr_en_out   = done_out && (rda_q != 5'd0);
  assign rd_addr_out = rda_q;
  assign rd_out      = done_out ? res : rd_q;

endmodule

// File: tb/tb_msrv32_muldiv_unit.sv
// Random + directed bench for msrv32_muldiv_unit.
// Results come from a plain-arithmetic RV32M model.
module tb_msrv32_muldiv_unit;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        start_in;
  logic [2:0]  funct3_in;
  logic [31:0] rs_1_in;
  logic [31:0] rs_2_in;
  logic [4:0]  rd_addr_in;
  logic        busy_out;
  logic        done_out;
  logic        wr_en_out;
  logic [4:0]  rd_addr_out;
  logic [31:0] rd_out;

  int n_chk = 0;
  int n_err = 0;

  msrv32_muldiv_unit dut (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .start_in    (start_in),
    .funct3_in   (funct3_in),
    .rs_1_in     (rs_1_in),
    .rs_2_in     (rs_2_in),
    .rd_addr_in  (rd_addr_in),
    .busy_out    (busy_out),
    .done_out    (done_out),
    .wr_en_out   (wr_en_out),
    .rd_addr_out (rd_addr_out),
    .rd_out      (rd_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(
      input logic [2:0] f,
      input logic [31:0] a,
      input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(
      input logic [2:0] f,
      input logic [31:0] a,
      input logic [31:0] b);
    if (!f[2]) begin
`ifdef MSRV32_FAST_MUL_EN
      return 1;
`else
      return 33;
`endif
    end
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // noise > 0: pulse start at that cycle of the op;
  // noise < 0: pulse start in the done cycle.
  task automatic run_op(input logic [2:0] f,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [4:0] rd,
                        input int noise);
    logic [31:0] e;
    int lat, k;
    logic bz;
    e   = ref_res(f, a, b);
    lat = ref_lat(f, a, b);
    start_in   = 1'b1;
    funct3_in  = f;
    rs_1_in    = a;
    rs_2_in    = b;
    rd_addr_in = rd;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    k  = 1;
    bz = 1'b1;
    while (!done_out && k < 100) begin
      if (!busy_out) bz = 1'b0;
      if (k == noise) begin
        start_in  = 1'b1;
        funct3_in = 3'($urandom);
        rs_1_in   = $urandom;
        rs_2_in   = $urandom;
      end
      @(posedge clk_in); #1;
      start_in = 1'b0;
      k++;
    end
    check("latency", k, lat);
    if (k >= 100) return;
    if (!busy_out) bz = 1'b0;
    check("busy_during", {31'd0, bz}, 32'd1);
    check("result", rd_out, e);
    check("wr_en", {31'd0, wr_en_out}, {31'd0, rd != 0});
    check("rd_addr", {27'd0, rd_addr_out}, {27'd0, rd});
    if (noise < 0) begin
      start_in  = 1'b1;
      funct3_in = 3'd0;
      rs_1_in   = $urandom;
    end
    @(posedge clk_in); #1;
    start_in = 1'b0;
    check("busy_after", {31'd0, busy_out}, 32'd0);
    check("done_after", {31'd0, done_out}, 32'd0);
    check("hold", rd_out, e);
  endtask

  initial begin
    logic flag;
    reset_in   = 1'b0;
    start_in   = 1'b0;
    funct3_in  = 3'd0;
    rs_1_in    = 32'd0;
    rs_2_in    = 32'd0;
    rd_addr_in = 5'd0;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_busy", {31'd0, busy_out}, 32'd0);
    check("rst_done", {31'd0, done_out}, 32'd0);
    check("rst_wr", {31'd0, wr_en_out}, 32'd0);
    check("rst_rd", rd_out, 32'd0);
    check("rst_addr", {27'd0, rd_addr_out}, 32'd0);
    reset_in = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 0);
    run_op(3'd5, 32'd100, 32'd7, 5'd7, 0);
    run_op(3'd7, 32'd100, 32'd7, 5'd8, 0);
    run_op(3'd5, 32'd5, 32'd0, 5'd9, 0);
    run_op(3'd6, 32'd5, 32'd0, 5'd10, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);
    run_op(3'd0, 32'd3, 32'd4, 5'd0, 0);
    run_op(3'd4, 32'd1000, 32'hFFFF_FFF5, 5'd13, 5);
    run_op(3'd7, 32'd12345, 32'd99, 5'd14, -1);

    // reset in cycle 10 of a divide
    start_in   = 1'b1;
    funct3_in  = 3'd4;
    rs_1_in    = 32'd5000;
    rs_2_in    = 32'd3;
    rd_addr_in = 5'd15;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    repeat (9) @(posedge clk_in);
    #1;
    reset_in = 1'b0;
    @(posedge clk_in); #1;
    reset_in = 1'b1;
    check("mid_rst_busy", {31'd0, busy_out}, 32'd0);
    check("mid_rst_rd", rd_out, 32'd0);
    flag = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_out || wr_en_out) flag = 1'b1;
      @(posedge clk_in); #1;
    end
    check("mid_rst_nodone", {31'd0, flag}, 32'd0);
    run_op(3'd0, 32'd3, 32'd4, 5'd16, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom), rnd_val(), rnd_val(),
             5'($urandom), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
